// File: rtl/ssi_quad_tx.sv
// ssi_quad_tx: quad-lane synchronous serial transmitter toward the ARM.
//
// Takes 32-bit words over a valid/ready handshake and sends each one as 8
// nibbles (MSB nibble first) on four data lanes. A gated serial clock runs
// alongside, and a frame-sync strobe marks the first bit period. Every line
// toward the link comes straight from a flop.
//
// Ports:
//   clk        system clock (110.592 MHz domain)
//   rst        synchronous, active-high reset
//   ena        block enable; words are accepted only while high
//   din_valid  upstream word valid
//   din_data   upstream 32-bit word
//   din_ready  block can accept a word this cycle
//   ssi_clk    serial clock, low when idle, receiver samples on rising edge
//   ssi_fss    frame sync, high for the first bit period of a frame
//   ssi_xdat   lane data, bit3 drives xdat3
//   busy       frame or inter-frame gap in progress
//   frame_cnt  number of completed frames (wraps)
module ssi_quad_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             din_valid,
    input  logic [31:0]      din_data,
    output logic             din_ready,
    output logic             ssi_clk,
    output logic             ssi_fss,
    output logic [3:0]       ssi_xdat,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned H     = CLK_DIV / 2;
    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // Phase index inside a bit period: 0..H-1 low, H..CLK_DIV-1 high.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // Phase after which the serial clock goes high.
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(H - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             fss_q, fss_d;
    logic [3:0]       xdat_q, xdat_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;

    // Ready depends only on state and ena; reset masks it so a word offered
    // during reset is never taken.
    always_comb begin
        din_ready = (state_q == ST_IDLE) && ena && !rst;
        accept    = din_valid && din_ready;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        fss_d   = fss_q;
        xdat_d  = xdat_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    // First nibble goes straight out; shreg holds the rest,
                    // left-aligned so the next nibble is always [31:28].
                    xdat_d  = din_data[31:28];
                    shreg_d = {din_data[27:0], 4'h0};
                    fss_d   = 1'b1;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end

            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                        xdat_d  = 4'h0;
                        fss_d   = 1'b0;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        xdat_d  = shreg_q[31:28];
                        shreg_d = {shreg_q[27:0], 4'h0};
                        fss_d   = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                    if (div_q == DIV_RISE) begin
                        sclk_d = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            fss_q   <= 1'b0;
            xdat_q  <= 4'h0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            fss_q   <= fss_d;
            xdat_q  <= xdat_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ssi_clk   = sclk_q;
    assign ssi_fss   = fss_q;
    assign ssi_xdat  = xdat_q;
    assign busy      = busy_q;
    assign frame_cnt = cnt_q;

endmodule
